uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Asynchronous serial receiver, 8 data bits, LSB first, 1 stop bit, no parity by default.
- Sits directly upstream of the frame bridge that hunts for the 0xAA header and collects 5 command bytes.
- Produces the one-cycle byte strobe `rxen` and byte bus `rxdb` that the bridge consumes.
- Rejects false starts and framing errors, so the bridge never sees a corrupted byte.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- BIT_CYC, CLK_HZ/BAUD (truncating integer division, =434 at defaults), clocks per bit; local, not overridable.

Ports:
- clk      in   1  system clock, rising edge.
- rst      in   1  synchronous, active-low reset.
- rs232_rx in   1  asynchronous serial line, idle high.
- rxen     out  1  one-clk pulse: valid byte on rxdb.
- rxdb     out  8  last good received byte.
- frm_err  out  1  one-clk pulse: stop bit sampled low.
- par_err  out  1  one-clk pulse: parity mismatch; tied 0 when parity is compiled out.
- rx_busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: clock is clk; reset is rst, synchronous, active-low.
- Reset values: rxen=0, frm_err=0, par_err=0, rx_busy=0, rxdb=8'h00, state=IDLE, synchronizer flops=1, counters=0.
- Input path: 2-flop synchronizer, then a 1-flop edge detector. Start is recognized on a 1->0 transition of the synchronized line.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE -> START on the detected falling edge; bit counter clears.
- START: at count BIT_CYC/2-1 (=216) sample the line.
  - High: false start; return to IDLE with no pulses.
  - Low: enter DATA and clear the counter.
- DATA: each time the counter reaches BIT_CYC-1, sample the line into shift[7] and shift right; bit index increments.
  - After index 7 is sampled, go to STOP (or PARITY when enabled).
- STOP: at BIT_CYC-1 sample the line.
  - High: rxdb<=shift and rxen=1 for exactly one clk.
  - Low: frm_err=1 for one clk; rxdb is unchanged.
  - Either way, return to IDLE in the same cycle, i.e. mid stop bit, so a back-to-back start edge is caught.
- Latency: rxen rises 2 (sync) + 1 (edge) + 217 + 9×434 clocks after the line's falling edge (≈4126 clk at defaults). Implementer fixes the exact constant; the bench checks ±2.
- rxdb holds its value between pulses; never changes without rxen.
- rxen and frm_err are mutually exclusive; at most one pulse per frame.
- Line held low (break): one frm_err, then IDLE waits for the line to return high. No new frame starts until a fresh 1->0 edge.
- Glitch shorter than half a bit: rejected at the START check.
- rst low mid-frame: IDLE on the next edge, no pulse emitted, partial shift data discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It samples the 9th bit at BIT_CYC-1 and checks even parity (XOR of 8 data bits and parity bit must be 0).
  - Mismatch: par_err=1 for one clk, the frame is still walked through STOP, and no rxen is issued.
  - frm_err takes priority reporting only if parity passed.
- Undefined: no PARITY state, par_err constantly 0, 8N1 timing.

Decomposition:
- Shared package ecs_uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit).
  - default CLK_HZ/BAUD constants.
  - frame header constant ECS_FRM_HDR=8'hAA, shared with the bridge.
- Natural sub-module: uart_bit_timer. It holds the 9-bit clock counter with clear input, half-bit and full-bit tick outputs, and is reusable by the future transmitter.

Test Plan:
- Send 0xAA as 8N1 at 115200: exactly one rxen; rxdb=8'hAA; rxen within ±2 clk of 4126 clk after the line's falling edge; frm_err stays 0.
- Send 0xAA,0x11,0x22,0x33,0x44,0x55 back-to-back with zero idle time: six rxen pulses with rxdb values in that order; rx_busy never drops for more than ~217 clk between frames.
- Drive a low glitch of 100 clk on the idle line: no rxen, no frm_err; rx_busy high for ≤220 clk, then 0.
- Send 0x3C with stop bit forced low after a prior good 0x5A: one frm_err pulse, no rxen, rxdb remains 8'h5A.
- Assert rst low for 3 clk during data bit 4 of 0x81, then send 0x5A cleanly: no pulse for the aborted frame; rxdb resets to 8'h00, then becomes 8'h5A with one rxen.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong): one par_err pulse and no rxen. Resend with parity bit 1: rxen with rxdb=8'h07.

Source files
------------

// File: rtl/ecs_uart_pkg.sv
// ============================================================================
// Module : ecs_uart_pkg
// Brief  : Shared UART constants: receiver state encoding, default line
//          settings and the frame header byte used by the command bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecs_uart_pkg;

  // Default system clock and line rate
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 115_200;

  // Header byte the downstream bridge hunts for
  localparam logic [7:0] ECS_FRM_HDR = 8'hAA;

  // Receiver state encoding, 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core_if.sv
// ============================================================================
// Module : uart_rx_core_if
// Brief  : Serial line input and received-byte outputs of the UART receiver.
//          master = receiver core, slave = line driver / byte consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_core_if;
  logic       rs232_rx;
  logic       rxen;
  logic [7:0] rxdb;
  logic       frm_err;
  logic       par_err;
  logic       rx_busy;

  modport master (
    input  rs232_rx,
    output rxen, rxdb, frm_err, par_err, rx_busy
  );

  modport slave (
    output rs232_rx,
    input  rxen, rxdb, frm_err, par_err, rx_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module : uart_bit_timer
// Brief  : Free-running bit-period counter with synchronous clear. Flags the
//          half-bit point and the last clock of a full bit; wraps on the
//          full-bit tick so consecutive bits need no explicit clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
  parameter int BIT_CYC = 434,
  parameter int CNT_W   = 9
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  output logic      o_half_tick,
  output logic      o_full_tick
);

  localparam logic [CNT_W-1:0] c_HALF = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count clocks within a bit; restart on clear or at the end of each bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_full_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_half_tick = (r_cnt == c_HALF);
  assign o_full_tick = (r_cnt == c_FULL);

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module : uart_rx_core
// Brief  : Asynchronous serial receiver, 8 data bits LSB first, 1 stop bit.
//          Rejects false starts (line high at mid start bit) and framing
//          errors so only clean bytes reach the command bridge.
//          Optional macro UART_RX_PARITY_EN adds an even-parity bit check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_core
  import ecs_uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  wire logic       clk,
  input  wire logic       rst,
  uart_rx_core_if.master  bus
);

  localparam int c_BIT_CYC = CLK_HZ / BAUD;
  localparam int c_CNT_W   = $clog2(c_BIT_CYC);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       w_fall;
  logic       w_half;
  logic       w_full;
  logic       w_tmr_clr;
  rx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_rxen;
  logic [7:0] r_rxdb;
  logic       r_frm_err;
  logic       r_busy;
`ifdef UART_RX_PARITY_EN
  logic       r_par_err;
  logic       r_par_bad;
  logic       w_par_bad;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.rs232_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  // Hold the timer at zero while idle and restart it at the mid start bit,
  // so every data/stop sample lands one full bit later, near mid bit.
  assign w_tmr_clr = (r_state == ST_IDLE) || ((r_state == ST_START) && w_half);

  uart_bit_timer #(
    .BIT_CYC (c_BIT_CYC),
    .CNT_W   (c_CNT_W)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_tmr_clr),
    .o_half_tick (w_half),
    .o_full_tick (w_full)
  );

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must come out zero
  assign w_par_bad = ^{r_shift, r_sync2};
`endif

  // Frame state machine with registered strobes and busy flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_idx     <= 3'd0;
      r_rxen    <= 1'b0;
      r_rxdb    <= 8'h00;
      r_frm_err <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rxen    <= 1'b0;
      r_frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_half) begin
            if (r_sync2) begin
              // Line went back high before mid bit: a glitch, not a start
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
              r_idx   <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (w_full) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full) begin
            r_par_bad <= w_par_bad;
            r_par_err <= w_par_bad;
            r_state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_full) begin
            // Leave mid stop bit so a back-to-back start edge is not missed
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (!r_par_bad) begin
`else
            begin
`endif
              if (r_sync2) begin
                r_rxen <= 1'b1;
                r_rxdb <= r_shift;
              end else begin
                r_frm_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rxen    = r_rxen;
  assign bus.rxdb    = r_rxdb;
  assign bus.frm_err = r_frm_err;
  assign bus.rx_busy = r_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.par_err = r_par_err;
`else
  assign bus.par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module : tb_uart_rx_core
// Brief  : Self-checking bench for uart_rx_core: table of single frames plus
//          directed back-to-back, glitch, reset-abort and parity sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

  localparam int BC = 50_000_000 / 115_200;  // 434 clocks per bit
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + 217 + 10 * 434;
`else
  localparam int LAT = 3 + 217 + 9 * 434;    // 4126
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  uart_rx_core_if bus ();

  uart_rx_core #(
    .CLK_HZ (50_000_000),
    .BAUD   (115_200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp line edges and strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts strobes, records received bytes and busy run lengths
  int         n_rxen = 0, n_frm = 0, n_par = 0, n_both = 0, n_bad_db = 0;
  int         t_rxen = 0;
  logic [7:0] got [16];
  logic [7:0] prev_db = 8'h00;
  int         low_run = 0, high_run = 0, max_low = 0, max_high = 0;
  logic       stat_clr = 1'b0;

  always @(negedge clk) begin
    if (bus.rxen) begin
      n_rxen <= n_rxen + 1;
      t_rxen <= cyc;
      got[n_rxen[3:0]] <= bus.rxdb;
    end
    if (bus.frm_err) n_frm <= n_frm + 1;
    if (bus.par_err) n_par <= n_par + 1;
    if (bus.rxen && bus.frm_err) n_both <= n_both + 1;
    if (rst && !bus.rxen && bus.rxdb != prev_db) n_bad_db <= n_bad_db + 1;
    prev_db <= bus.rxdb;
    if (stat_clr) begin
      low_run <= 0; high_run <= 0; max_low <= 0; max_high <= 0;
    end else if (bus.rx_busy) begin
      high_run <= high_run + 1;
      if (low_run > max_low) max_low <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
      if (high_run > max_high) max_high <= high_run;
      high_run <= 0;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int t_fall = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // All line tasks start and end at #1 after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rs232_rx = b;
    idle(BC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input int hold_low);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
    if (hold_low > 0) begin
      bus.rs232_rx = 1'b0;
      idle(hold_low);
    end
    bus.rs232_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_rxen;
    int         exp_frm;
    logic [7:0] exp_db;
  } vec_t;

  vec_t       vec [6];
  logic [7:0] b2b [6];

  initial begin
    int b_rx, b_fr, b_pe;

    vec[0] = '{8'hAA, 1'b1, 0,    1, 0, 8'hAA};
    vec[1] = '{8'h5A, 1'b1, 0,    1, 0, 8'h5A};
    vec[2] = '{8'h3C, 1'b0, 0,    0, 1, 8'h5A};  // stop low: rxdb keeps 5A
    vec[3] = '{8'h00, 1'b0, 1500, 0, 1, 8'h5A};  // break: one frm_err only
    vec[4] = '{8'hFF, 1'b1, 0,    1, 0, 8'hFF};
    vec[5] = '{8'h01, 1'b1, 0,    1, 0, 8'h01};
    b2b[0] = 8'hAA; b2b[1] = 8'h11; b2b[2] = 8'h22;
    b2b[3] = 8'h33; b2b[4] = 8'h44; b2b[5] = 8'h55;

    bus.rs232_rx = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_rxen",    bus.rxen,    0);
    chk("reset_rxdb",    bus.rxdb,    0);
    chk("reset_frm_err", bus.frm_err, 0);
    chk("reset_par_err", bus.par_err, 0);
    chk("reset_busy",    bus.rx_busy, 0);
    rst = 1'b1;
    idle(20);

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      b_rx = n_rxen; b_fr = n_frm; b_pe = n_par;
      send_frame(vec[v].data, vec[v].stop, 1'b0, vec[v].hold);
      idle(20);
      chk($sformatf("v%0d_rxen_cnt", v), n_rxen - b_rx, vec[v].exp_rxen);
      chk($sformatf("v%0d_frm_cnt", v),  n_frm - b_fr,  vec[v].exp_frm);
      chk($sformatf("v%0d_par_cnt", v),  n_par - b_pe,  0);
      chk($sformatf("v%0d_rxdb", v),     bus.rxdb,      vec[v].exp_db);
      if (vec[v].exp_rxen == 1)
        chk_rng($sformatf("v%0d_latency", v), t_rxen - t_fall, LAT - 2, LAT + 2);
    end

    // Back-to-back frames with no idle between stop and next start
    stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
    b_rx = n_rxen;
    for (int i = 0; i < 6; i++) send_frame(b2b[i], 1'b1, 1'b0, 0);
    idle(20);
    chk("b2b_rxen_cnt", n_rxen - b_rx, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_byte%0d", i), got[(b_rx + i) % 16], b2b[i]);
    chk_rng("b2b_busy_gap", max_low, 1, 220);

    // Short low glitch on idle line
    stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
    b_rx = n_rxen; b_fr = n_frm;
    bus.rs232_rx = 1'b0;
    idle(100);
    bus.rs232_rx = 1'b1;
    idle(400);
    chk("glitch_rxen", n_rxen - b_rx, 0);
    chk("glitch_frm",  n_frm - b_fr,  0);
    chk_rng("glitch_busy_len", max_high, 200, 220);
    chk("glitch_busy_end", bus.rx_busy, 0);

    // Reset during data bit 4 of 0x81; the sender abandons the frame too
    b_rx = n_rxen; b_fr = n_frm;
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 1; i < 4; i++) drive_bit(1'b0);
    bus.rs232_rx = 1'b0;
    idle(200);
    rst = 1'b0;
    bus.rs232_rx = 1'b1;
    idle(3);
    rst = 1'b1;
    chk("abort_rxdb_reset", bus.rxdb, 0);
    chk("abort_busy",       bus.rx_busy, 0);
    idle(1000);
    chk("abort_no_rxen", n_rxen - b_rx, 0);
    chk("abort_no_frm",  n_frm - b_fr,  0);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    idle(20);
    chk("after_abort_rxen", n_rxen - b_rx, 1);
    chk("after_abort_rxdb", bus.rxdb, 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Wrong parity, then correct parity
    b_rx = n_rxen; b_pe = n_par;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(20);
    chk("par_bad_err",  n_par - b_pe,  1);
    chk("par_bad_rxen", n_rxen - b_rx, 0);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(20);
    chk("par_ok_err",  n_par - b_pe,  1);
    chk("par_ok_rxen", n_rxen - b_rx, 1);
    chk("par_ok_rxdb", bus.rxdb, 8'h07);
`endif

    chk("rxen_frm_exclusive", n_both, 0);
    chk("rxdb_only_with_rxen", n_bad_db, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
